e300_gpio_pad_ctrl: RTL and testbench
=====================================

Name: e300_gpio_pad_ctrl

Overview:
- Parametrised GPIO pad controller that sits between the E300 platform's per-pin iof/GPIO signals (oval/oe/ie out, ival in) and the FPGA pads.
- Drives the bidirectional pads and synchronises inputs into the clock domain.
- Applies an optional per-pin debounce filter.
- Records sticky rise/fall events with a maskable interrupt.
- Supersedes the flat per-pin tri-state wiring at the top level for an NPINS-wide bank.

Parameters:
NPINS, 32, number of pins in the bank (1..32).
SYNC_STAGES, 2, input synchroniser depth in flops (min 2).
DBNC_CYCLES, 16, consecutive stable cycles required when debounce is enabled (min 2); counter width is clog2(DBNC_CYCLES).

Ports:
clock  in  1  system clock; single clock domain.
reset_n  in  1  asynchronous active-low reset.
core_o_oval  in  NPINS  per-pin output value from platform.
core_o_oe  in  NPINS  per-pin output enable from platform.
core_o_ie  in  NPINS  per-pin input enable from platform.
core_i_ival  out  NPINS  filtered, synchronised input value to platform.
pad_io  inout  NPINS  FPGA pads.
dbnc_en  in  NPINS  per-pin debounce enable (quasi-static).
evt_clr  in  NPINS  per-pin pulse clearing both event flags.
irq_mask  in  NPINS  per-pin interrupt enable.
evt_rise  out  NPINS  sticky rising-edge flags.
evt_fall  out  NPINS  sticky falling-edge flags.
irq  out  1  OR of masked events.

Behaviour:
- Interface: one clock, `clock`; reset `reset_n`, asynchronous, active-low. All flops reset to 0: `core_i_ival`=0, `evt_rise`/`evt_fall`=0, `irq`=0, counters=0.
- Output path (combinational): `pad_io[i]` = `core_o_oe[i]` ? `core_o_oval[i]` : Z.
- Raw input: `raw[i]` = `pad_io[i]` & `core_o_ie[i]`. Z/X on the pad is the board's concern.
- Synchroniser: SYNC_STAGES flop chain per pin gives `sync[i]`.
- Filter, `dbnc_en[i]`=0:
  - `stable[i]` <= `sync[i]` every cycle; counter held at 0.
  - Latency pad->`core_i_ival` = SYNC_STAGES+1 cycles.
- Filter, `dbnc_en[i]`=1:
  - If `sync`==`stable`: counter <= 0.
  - If `sync`!=`stable` and counter < DBNC_CYCLES-1: counter++.
  - If `sync`!=`stable` and counter == DBNC_CYCLES-1: `stable` <= `sync`, counter <= 0.
  - A glitch shorter than DBNC_CYCLES synced cycles never reaches `stable`.
  - Latency = SYNC_STAGES+DBNC_CYCLES cycles.
- `core_i_ival` = `stable` (registered).
- Toggling `dbnc_en` mid-count clears the counter; no spurious update results.
- Events:
  - On the cycle `stable[i]` goes 0->1, `evt_rise[i]` is set, visible the next cycle.
  - On 1->0, `evt_fall[i]` is set the same way.
  - `evt_clr[i]` clears both flags.
  - Set and clear in the same cycle: set wins.
  - Flags stay set until cleared.
- `irq` = |((`evt_rise`|`evt_fall`) & `irq_mask`), combinational from registers. `irq_mask` gates `irq` only, never the flags.
- Deasserting `core_o_ie` forces `raw`=0 and propagates as a normal falling edge after the filter latency.
- Reset asserted mid-debounce: counter, `stable` and flags clear immediately. After release, a high pad produces a rise event once filtered, since the reset value of `stable` is 0.

Optional Feature:
- Macro: GPIO_LOOPBACK_EN.
- Defined:
  - Adds input port `lpbk_en` (1 bit).
  - When `lpbk_en`=1, `raw[i]` = `core_o_oval[i]` & `core_o_ie[i]`, ignoring the pad.
  - Pads are still driven per `core_o_oe`.
  - Switching `lpbk_en` takes effect at the synchroniser input; filter and events behave normally.
- Undefined: no `lpbk_en` port; `raw` always comes from the pad.

Test Plan:
1. Reset release, `oe`=0, `ie`=0xFFFFFFFF, pad[5] driven 1, `dbnc_en`=0 -> `core_i_ival[5]`=1 exactly 3 cycles after the pad change; `evt_rise[5]`=1 one cycle later; `irq`=1 only if `irq_mask[5]`=1.
2. `dbnc_en[3]`=1, DBNC_CYCLES=16, pad[3] pulse high for 10 cycles -> `core_i_ival[3]` stays 0 and no events. Pad held high 20 cycles -> `core_i_ival[3]`=1 at SYNC_STAGES+16 cycles after the edge.
3. `core_o_oe[7]`=1, `oval[7]` toggling -> `pad_io[7]` follows combinationally. `oe[7]`=0 -> `pad_io[7]`=Z.
4. `evt_fall[2]` pending and a new fall arrives in the same cycle as `evt_clr[2]`=1 -> `evt_fall[2]` remains 1. `evt_clr[2]` alone -> both flags 0 and `irq` drops the same cycle.
5. `reset_n` asserted mid-debounce count (counter=9) -> all outputs 0 asynchronously. After release with the pad high, the rise is re-detected after the full latency.
6. GPIO_LOOPBACK_EN defined, `lpbk_en`=1, `oe`=0, `oval[0]`=1, `ie[0]`=1, pad floating -> `core_i_ival[0]`=1 after 3 cycles.

Source files
------------

// File: rtl/e300_gpio_pad_ctrl.sv
// GPIO pad bank for the E300 platform: tri-state pad drive, input sync, optional debounce,
// sticky edge events with maskable irq. Define GPIO_LOOPBACK_EN to add the lpbk_en port.
module e300_gpio_pad_ctrl #(
  parameter int unsigned NPINS       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DBNC_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NPINS-1:0] core_o_oval,
  input  logic [NPINS-1:0] core_o_oe,
  input  logic [NPINS-1:0] core_o_ie,
  output logic [NPINS-1:0] core_i_ival,
  inout  wire  [NPINS-1:0] pad_io,
  input  logic [NPINS-1:0] dbnc_en,
  input  logic [NPINS-1:0] evt_clr,
  input  logic [NPINS-1:0] irq_mask,
  output logic [NPINS-1:0] evt_rise,
  output logic [NPINS-1:0] evt_fall,
  output logic             irq
`ifdef GPIO_LOOPBACK_EN
  ,
  input  logic             lpbk_en
`endif
);

  localparam int unsigned CNT_W = (DBNC_CYCLES > 1) ? $clog2(DBNC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DBNC_CYCLES - 1);

  logic [NPINS-1:0]                  raw_c;
  logic [SYNC_STAGES-1:0][NPINS-1:0] sync_q;
  logic [NPINS-1:0]                  sync_c;
  logic [NPINS-1:0]                  stable_q, stable_d;
  logic [NPINS-1:0]                  stable_prev_q;
  logic [NPINS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [NPINS-1:0]                  evt_rise_q, evt_rise_d;
  logic [NPINS-1:0]                  evt_fall_q, evt_fall_d;

  // Pads are released whenever the platform does not enable the output
  for (genvar g = 0; g < NPINS; g++) begin : g_pad
    assign pad_io[g] = core_o_oe[g] ? core_o_oval[g] : 1'bz;
  end

`ifdef GPIO_LOOPBACK_EN
  always_comb begin
    raw_c = lpbk_en ? (core_o_oval & core_o_ie) : (pad_io & core_o_ie);
  end
`else
  always_comb begin
    raw_c = pad_io & core_o_ie;
  end
`endif

  assign sync_c = sync_q[SYNC_STAGES-1];

  // Per-pin filter: bypass, or require DBNC_CYCLES consecutive differing samples
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < int'(NPINS); i++) begin
      if (!dbnc_en[i]) begin
        stable_d[i] = sync_c[i];
      end else if (sync_c[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync_c[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Edges are taken from the registered stable value, so flags land one cycle after ival
  always_comb begin
    evt_rise_d = (stable_q & ~stable_prev_q) | (evt_rise_q & ~evt_clr);
    evt_fall_d = (~stable_q & stable_prev_q) | (evt_fall_q & ~evt_clr);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q        <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      cnt_q         <= '0;
      evt_rise_q    <= '0;
      evt_fall_q    <= '0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], raw_c};
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      cnt_q         <= cnt_d;
      evt_rise_q    <= evt_rise_d;
      evt_fall_q    <= evt_fall_d;
    end
  end

  assign core_i_ival = stable_q;
  assign evt_rise    = evt_rise_q;
  assign evt_fall    = evt_fall_q;
  assign irq         = |((evt_rise_q | evt_fall_q) & irq_mask);

endmodule

// File: tb/tb_e300_gpio_pad_ctrl.sv
// Directed bench for e300_gpio_pad_ctrl (default parameters); loopback case under GPIO_LOOPBACK_EN.
module tb_e300_gpio_pad_ctrl;

  localparam int unsigned NPINS = 32;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [NPINS-1:0] core_o_oval, core_o_oe, core_o_ie;
  logic [NPINS-1:0] core_i_ival;
  wire  [NPINS-1:0] pad_io;
  logic [NPINS-1:0] dbnc_en, evt_clr, irq_mask;
  logic [NPINS-1:0] evt_rise, evt_fall;
  logic             irq;
  logic [NPINS-1:0] pad_drv, pad_en;
`ifdef GPIO_LOOPBACK_EN
  logic             lpbk_en;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  e300_gpio_pad_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .core_o_oval (core_o_oval),
    .core_o_oe   (core_o_oe),
    .core_o_ie   (core_o_ie),
    .core_i_ival (core_i_ival),
    .pad_io      (pad_io),
    .dbnc_en     (dbnc_en),
    .evt_clr     (evt_clr),
    .irq_mask    (irq_mask),
    .evt_rise    (evt_rise),
    .evt_fall    (evt_fall),
    .irq         (irq)
`ifdef GPIO_LOOPBACK_EN
    ,
    .lpbk_en     (lpbk_en)
`endif
  );

  // Board-side pad drivers, released per pin
  for (genvar g = 0; g < NPINS; g++) begin : g_board
    assign pad_io[g] = pad_en[g] ? pad_drv[g] : 1'bz;
  end

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  logic seen;

  initial begin
    reset_n     = 1'b0;
    core_o_oval = '0;
    core_o_oe   = '0;
    core_o_ie   = '1;
    dbnc_en     = '0;
    evt_clr     = '0;
    irq_mask    = '0;
    pad_drv     = '0;
    pad_en      = '1;
`ifdef GPIO_LOOPBACK_EN
    lpbk_en     = 1'b0;
`endif
    tick(3);
    check("rst_ival", core_i_ival, 32'h0);
    check("rst_rise", evt_rise, 32'h0);
    check("rst_fall", evt_fall, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    tick(5);

    // 1: bypass latency and masked irq on pin 5
    pad_drv[5] = 1'b1;
    tick(1); check("t1_lat1", 32'(core_i_ival[5]), 32'h0);
    tick(1); check("t1_lat2", 32'(core_i_ival[5]), 32'h0);
    tick(1); check("t1_lat3", 32'(core_i_ival[5]), 32'h1);
    check("t1_rise_early", 32'(evt_rise[5]), 32'h0);
    tick(1); check("t1_rise", 32'(evt_rise[5]), 32'h1);
    check("t1_fall", 32'(evt_fall[5]), 32'h0);
    check("t1_irq_masked", 32'(irq), 32'h0);
    irq_mask = 32'h0000_0020;
    #1; check("t1_irq_unmasked", 32'(irq), 32'h1);
    evt_clr = 32'h0000_0020;
    tick(1);
    evt_clr = '0;
    check("t1_clr", 32'(evt_rise[5]), 32'h0);
    check("t1_irq_clr", 32'(irq), 32'h0);

    // 2: debounce on pin 3, 10-cycle glitch rejected, then full latency
    dbnc_en = 32'h0000_0008;
    tick(2);
    seen = 1'b0;
    pad_drv[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin tick(1); seen |= core_i_ival[3]; end
    pad_drv[3] = 1'b0;
    for (int k = 0; k < 30; k++) begin tick(1); seen |= core_i_ival[3]; end
    check("t2_glitch_ival", 32'(seen), 32'h0);
    check("t2_glitch_evt", 32'(evt_rise[3] | evt_fall[3]), 32'h0);
    pad_drv[3] = 1'b1;
    tick(17); check("t2_lat17", 32'(core_i_ival[3]), 32'h0);
    tick(1);  check("t2_lat18", 32'(core_i_ival[3]), 32'h1);
    tick(1);  check("t2_rise", 32'(evt_rise[3]), 32'h1);

    // 3: pad output path on pin 7
    pad_en[7]      = 1'b0;
    core_o_oe[7]   = 1'b1;
    core_o_oval[7] = 1'b1;
    #1; check("t3_drive1", 32'(pad_io[7]), 32'h1);
    core_o_oval[7] = 1'b0;
    #1; check("t3_drive0", 32'(pad_io[7]), 32'h0);
    core_o_oe[7]   = 1'b0;
    pad_en[7]      = 1'b1;
    pad_drv[7]     = 1'b0;
    core_o_oval[7] = 1'b1;
    #1; check("t3_release0", 32'(pad_io[7]), 32'h0);
    pad_drv[7]     = 1'b1;
    core_o_oval[7] = 1'b0;
    #1; check("t3_release1", 32'(pad_io[7]), 32'h1);
    tick(6);
    evt_clr = '1;
    tick(1);
    evt_clr = '0;
    check("t3_clr_rise", evt_rise, 32'h0);
    check("t3_clr_fall", evt_fall, 32'h0);

    // 4: set beats clear on pin 2
    pad_drv[2] = 1'b1; tick(5);
    pad_drv[2] = 1'b0; tick(5);
    pad_drv[2] = 1'b1; tick(5);
    pad_drv[2] = 1'b0;
    tick(3);
    evt_clr = 32'h0000_0004;
    tick(1);
    evt_clr = '0;
    check("t4_set_wins", 32'(evt_fall[2]), 32'h1);
    check("t4_rise_cleared", 32'(evt_rise[2]), 32'h0);
    irq_mask = 32'h0000_0004;
    #1; check("t4_irq_on", 32'(irq), 32'h1);
    evt_clr = 32'h0000_0004;
    tick(1);
    evt_clr = '0;
    check("t4_clr_fall", 32'(evt_fall[2]), 32'h0);
    check("t4_irq_off", 32'(irq), 32'h0);

    // 5: async reset mid-debounce on pin 3 (counter at 9), then re-detect
    pad_drv[3] = 1'b0;
    tick(11);
    reset_n = 1'b0;
    #1;
    check("t5_rst_ival", core_i_ival, 32'h0);
    check("t5_rst_rise", evt_rise, 32'h0);
    check("t5_rst_fall", evt_fall, 32'h0);
    check("t5_rst_irq", 32'(irq), 32'h0);
    pad_drv[3] = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(17); check("t5_lat17", 32'(core_i_ival[3]), 32'h0);
    tick(1);  check("t5_lat18", 32'(core_i_ival[3]), 32'h1);
    tick(1);  check("t5_rise3", 32'(evt_rise[3]), 32'h1);
    check("t5_rise5", 32'(evt_rise[5]), 32'h1);
    check("t5_irq", 32'(irq), 32'h0);

`ifdef GPIO_LOOPBACK_EN
    // 6: loopback feeds oval into the synchroniser while the pad stays low
    pad_drv[0]     = 1'b0;
    core_o_oval[0] = 1'b1;
    lpbk_en        = 1'b1;
    tick(2); check("t6_lat2", 32'(core_i_ival[0]), 32'h0);
    tick(1); check("t6_lat3", 32'(core_i_ival[0]), 32'h1);
    lpbk_en = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
